// File: rtl/usr_pkg.sv
// Shared types for the universal shift register:
// operation modes and burst controller states.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_CLR  = 3'b111
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/usr_shift_unit.sv
// Combinational next-value datapath for the universal
// shift register.
module usr_shift_unit
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  mode_e            mode,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] in,
    input  logic             msb_in,
    input  logic             lsb_in,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = cur;
        unique case (mode)
            MODE_HOLD: nxt = cur;
            MODE_SHR:  nxt = {msb_in, cur[WIDTH-1:1]};
            MODE_SHL:  nxt = {cur[WIDTH-2:0], lsb_in};
            MODE_LOAD: nxt = in;
            MODE_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
            MODE_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
            MODE_CLR:  nxt = '0;
            default:   nxt = cur;
        endcase
    end

endmodule

// File: rtl/param_universal_shift_reg.sv
// Universal shift register with single-step operation and
// a counted burst mode for the shift/rotate operations.
module param_universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             Clear_b,
    input  logic [2:0]       sel_line,
    input  logic [WIDTH-1:0] in,
    input  logic             msb_in,
    input  logic             lsb_in,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_cnt,
    output logic [WIDTH-1:0] out,
    output logic             msb_out,
    output logic             lsb_out,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_n;
    mode_e            mode_q, mode_n, op_mode, sel_mode;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic             is_shift;
    logic             busy_q, done_q;

    assign sel_mode = mode_e'(sel_line);
    assign is_shift = sel_mode inside
        {MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR};

    // The register holds (op_mode = HOLD) on the accept edge
    // and in DONE; bursts use the mode latched at accept.
    always_comb begin
        state_n = state_q;
        mode_n  = mode_q;
        cnt_n   = cnt_q;
        op_mode = MODE_HOLD;
        unique case (state_q)
            ST_IDLE: begin
                if (start && is_shift) begin
                    mode_n  = sel_mode;
                    cnt_n   = shift_cnt;
                    state_n = (shift_cnt == '0) ? ST_DONE : ST_BUSY;
                end else begin
                    op_mode = sel_mode;
                end
            end
            ST_BUSY: begin
                op_mode = mode_q;
                cnt_n   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_n = ST_DONE;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    usr_shift_unit #(
        .WIDTH (WIDTH)
    ) u_shift (
        .mode   (op_mode),
        .cur    (data_q),
        .in     (in),
        .msb_in (msb_in),
        .lsb_in (lsb_in),
        .nxt    (data_n)
    );

    always_ff @(posedge CLK) begin
        if (!Clear_b) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_HOLD;
            cnt_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            mode_q  <= mode_n;
            cnt_q   <= cnt_n;
            data_q  <= data_n;
            busy_q  <= (state_n == ST_BUSY);
            done_q  <= (state_n == ST_DONE);
        end
    end

    assign out     = data_q;
    assign msb_out = data_q[WIDTH-1];
    assign lsb_out = data_q[0];
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_param_universal_shift_reg.sv
// Directed bench for param_universal_shift_reg (WIDTH=8, CNT_W=4).
module tb_param_universal_shift_reg;

    logic       CLK = 1'b0;
    logic       Clear_b;
    logic [2:0] sel_line;
    logic [7:0] in;
    logic       msb_in, lsb_in, start;
    logic [3:0] shift_cnt;
    logic [7:0] out;
    logic       msb_out, lsb_out, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    param_universal_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .CLK       (CLK),
        .Clear_b   (Clear_b),
        .sel_line  (sel_line),
        .in        (in),
        .msb_in    (msb_in),
        .lsb_in    (lsb_in),
        .start     (start),
        .shift_cnt (shift_cnt),
        .out       (out),
        .msb_out   (msb_out),
        .lsb_out   (lsb_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] eo,
                             input logic eb, input logic ed);
        chk({tag, ".out"}, 32'(out), 32'(eo));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    logic [7:0] rol_exp [3] = '{8'h03, 8'h06, 8'h0C};

    initial begin
        Clear_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sel_line  = 3'($urandom);
            in        = 8'($urandom);
            msb_in    = 1'($urandom);
            lsb_in    = 1'($urandom);
            start     = 1'($urandom);
            shift_cnt = 4'($urandom);
            step();
        end
        chk_state("reset", 8'h00, 1'b0, 1'b0);
        Clear_b = 1'b1;
        start = 1'b0;
        shift_cnt = 4'd0;
        msb_in = 1'b0;
        lsb_in = 1'b0;

        sel_line = 3'b011; in = 8'hB5;
        step();
        chk("load", 32'(out), 32'hB5);
        chk("msb_out", 32'(msb_out), 32'd1);
        chk("lsb_out", 32'(lsb_out), 32'd1);
        sel_line = 3'b000; in = 8'h00;
        for (int i = 0; i < 3; i++) step();
        chk_state("hold", 8'hB5, 1'b0, 1'b0);

        sel_line = 3'b001; msb_in = 1'b1;
        step();
        chk("shr", 32'(out), 32'hDA);
        sel_line = 3'b010; lsb_in = 1'b0;
        step();
        chk("shl", 32'(out), 32'hB4);

        // start with a non-shift mode is ignored: plain load
        sel_line = 3'b011; in = 8'h81; start = 1'b1; shift_cnt = 4'd3;
        step();
        chk_state("load_start", 8'h81, 1'b0, 1'b0);

        sel_line = 3'b101; start = 1'b1; shift_cnt = 4'd3;
        step();
        chk_state("rol_acc", 8'h81, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel_line = 3'($urandom);
            in = 8'($urandom);
            step();
            chk_state($sformatf("rol%0d", i), rol_exp[i],
                      (i < 2), (i == 2));
        end
        sel_line = 3'b000;
        step();
        chk_state("rol_idle", 8'h0C, 1'b0, 1'b0);

        sel_line = 3'b011; in = 8'h90;
        step();
        sel_line = 3'b110; shift_cnt = 4'd2; start = 1'b1;
        step();
        chk_state("asr_acc", 8'h90, 1'b1, 1'b0);
        start = 1'b0; sel_line = 3'b000;
        step();
        chk_state("asr0", 8'hC8, 1'b1, 1'b0);
        step();
        chk_state("asr1", 8'hE4, 1'b0, 1'b1);
        step();
        chk_state("asr_idle", 8'hE4, 1'b0, 1'b0);

        sel_line = 3'b110; shift_cnt = 4'd0; start = 1'b1;
        step();
        chk_state("zero_cnt", 8'hE4, 1'b0, 1'b1);
        start = 1'b0; sel_line = 3'b000;
        step();
        chk_state("zero_idle", 8'hE4, 1'b0, 1'b0);

        sel_line = 3'b010; shift_cnt = 4'd15; start = 1'b1; lsb_in = 1'b1;
        step();
        start = 1'b0; sel_line = 3'b000;
        for (int i = 0; i < 4; i++) step();
        chk_state("long4", 8'h4F, 1'b1, 1'b0);
        Clear_b = 1'b0;
        step();
        chk_state("abort", 8'h00, 1'b0, 1'b0);
        Clear_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state($sformatf("post%0d", i), 8'h00, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/param_universal_shift_reg.md
PARAM_UNIVERSAL_SHIFT_REG -- requirements
Module: param_universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width; legal values are WIDTH >= 2.
REQ-002 Parameter CNT_W, default 4, width of the burst shift count.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 Clear_b  input  1  reset, synchronous, active-low.
REQ-005 sel_line  input  3  operation mode: 000 hold, 001 shift right, 010 shift left, 011 parallel load, 100 rotate right, 101 rotate left, 110 arithmetic shift right, 111 clear.
REQ-006 in  input  WIDTH  parallel load data.
REQ-007 msb_in  input  1  serial input entering bit WIDTH-1 on shift right.
REQ-008 lsb_in  input  1  serial input entering bit 0 on shift left.
REQ-009 start  input  1  burst request, sampled in IDLE only.
REQ-010 shift_cnt  input  CNT_W  number of burst steps.
REQ-011 out  output  WIDTH  register contents.
REQ-012 msb_out / lsb_out  output  1 each  equal to out[WIDTH-1] and out[0].
REQ-013 busy  output  1  high while a burst is in progress.
REQ-014 done  output  1  one-cycle pulse marking burst completion.

Function
REQ-015 Operations: shift right gives {msb_in, out[WIDTH-1:1]}; shift left gives {out[WIDTH-2:0], lsb_in}; rotates wrap the end bit; arithmetic shift right replicates out[WIDTH-1]; clear gives all zeros.
REQ-016 FSM states are IDLE, BUSY and DONE.
REQ-017 In IDLE with start=0, the operation selected by sel_line is applied once at each edge (single-step mode).
REQ-018 In IDLE with start=1, sel_line in {001,010,100,101,110} and shift_cnt!=0, the FSM latches mode and count, holds the register at that edge, and moves to BUSY.
REQ-019 In IDLE with start=1 and shift_cnt=0, the FSM moves to DONE and holds the register; no shift occurs.
REQ-020 In IDLE with start=1 and sel_line in {000,011,111}, start is ignored and the single-step operation applies.
REQ-021 In BUSY, the latched mode is applied once per edge for exactly N edges (N = latched count).
- sel_line, in, start and shift_cnt are ignored.
- msb_in and lsb_in are sampled live at every step.
REQ-022 At the Nth BUSY step the FSM moves to DONE.
REQ-023 busy is high for exactly N cycles, registered, starting the cycle after the start edge.
REQ-024 In DONE: done=1 and busy=0; the register holds; start is ignored; the next state is IDLE unconditionally.
REQ-025 done is registered and high for one cycle only.
REQ-026 Latency: a burst accepted at edge k produces its final value after edge k+N, with done high in the following cycle.

Reset
REQ-027 When Clear_b=0 at an edge: out=0, FSM=IDLE, busy=0, done=0, latched count=0.
REQ-028 Reset takes priority over every operation, including a burst in progress or the DONE state; no done pulse is produced for an aborted burst.
REQ-029 All outputs are fully defined starting with the first edge at which Clear_b=0.

Structure
REQ-030 A shared package usr_pkg holds the mode enum (3-bit, values per REQ-005) and the state enum (IDLE, BUSY, DONE).
REQ-031 The next-value datapath is a combinational sub-module usr_shift_unit (inputs: mode, out, in, msb_in, lsb_in; output: next value), instantiated once.
REQ-032 The FSM, the count register and the data register reside in the top module.

Verification (WIDTH=8, CNT_W=4)
REQ-033 Hold Clear_b=0 for 2 edges with random inputs -> out=0x00, busy=0, done=0.
REQ-034 sel=011, in=0xB5, one edge -> out=0xB5; then sel=000 for 3 edges -> out stays 0xB5.
REQ-035 From 0xB5: sel=001 with msb_in=1 -> 0xDA; then sel=010 with lsb_in=0 -> 0xB4.
REQ-036 From 0x81: sel=101, shift_cnt=3, start pulsed for one cycle -> out 0x03, 0x06, 0x0C with busy=1 for 3 cycles, then done=1 for one cycle, then IDLE; sel_line toggling during BUSY has no effect.
REQ-037 From 0x90: sel=110, shift_cnt=2, start -> 0xC8, then 0xE4, then a done pulse; start with shift_cnt=0 -> done pulse next cycle and out unchanged.
REQ-038 Burst with shift_cnt=15, then Clear_b=0 at the 5th BUSY cycle -> out=0x00, busy=0, and no done pulse.
